// File: rtl/bp_fe_queue_enq.sv
// FE->BE queue transmitter: packs fetch results or FE exceptions into
// bp_fe_queue_s messages and buffers them in an els_p-entry circular FIFO
// presented to the back end with a valid/yumi handshake.
//
// Message layout (MSB first):
//   [msg_w-1]        msg_type (e_fe_fetch / e_fe_exception)
//   fetch payload:   {pc, instr, branch_metadata_fwd}, upper-aligned padding zero
//   exception:       {zero pad, vaddr, exception_code}

package bp_fe_queue_enq_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_default_cfg = 2'd1
  } bp_params_e;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_msg_type_e;

  typedef enum logic [1:0] {
    e_instr_misaligned   = 2'd0,
    e_itlb_miss          = 2'd1,
    e_instr_access_fault = 2'd2,
    e_instr_page_fault   = 2'd3
  } bp_fe_exception_code_e;

  function automatic int cfg_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  function automatic int cfg_br_metadata_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 35;
      default:          return 35;
    endcase
  endfunction

  // Message = 1 type bit + the wider of the fetch / exception payloads.
  function automatic int bp_fe_queue_width(input int vaddr_w, input int meta_w);
    int fetch_w;
    int exc_w;
    fetch_w = vaddr_w + 32 + meta_w;
    exc_w   = vaddr_w + $bits(bp_fe_exception_code_e);
    return 1 + ((fetch_w > exc_w) ? fetch_w : exc_w);
  endfunction

endpackage

module bp_fe_queue_enq
  import bp_fe_queue_enq_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int els_p = 4,
  localparam int vaddr_width_p = cfg_vaddr_width(bp_params_p),
  localparam int branch_metadata_fwd_width_p = cfg_br_metadata_width(bp_params_p),
  localparam int fe_queue_width_lp = bp_fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic                                   fetch_v_i,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [31:0]                            fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
  output logic                                   fetch_yumi_o,

  input  logic                                   exc_v_i,
  input  logic [vaddr_width_p-1:0]               exc_vaddr_i,
  input  logic [$bits(bp_fe_exception_code_e)-1:0] exc_code_i,
  output logic                                   exc_yumi_o,

  output logic                                   enq_ready_o,
  input  logic                                   flush_i,

  output logic [fe_queue_width_lp-1:0]           fe_queue_o,
  output logic                                   fe_queue_v_o,
  input  logic                                   fe_queue_yumi_i
);

  localparam int idx_w   = $clog2(els_p);
  localparam int ptr_w   = idx_w + 1;
  localparam int fetch_w = vaddr_width_p + 32 + branch_metadata_fwd_width_p;
  localparam int exc_w   = vaddr_width_p + $bits(bp_fe_exception_code_e);
  localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);

  logic [ptr_w-1:0]             r_wptr;
  logic [ptr_w-1:0]             r_rptr;
  logic [fe_queue_width_lp-1:0] r_mem [els_p];

  logic                         w_full;
  logic                         w_empty;
  logic                         w_enq;
  logic                         w_deq;
  logic [fe_queue_width_lp-1:0] w_msg;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[idx_w-1:0] == r_rptr[idx_w-1:0]) &&
                   (r_wptr[idx_w] != r_rptr[idx_w]);

  assign enq_ready_o  = ~w_full & ~reset_i;
  assign fe_queue_v_o = ~w_empty;
  assign fe_queue_o   = r_mem[r_rptr[idx_w-1:0]];

  assign w_enq = (exc_v_i | fetch_v_i) & enq_ready_o & ~flush_i;
  assign w_deq = fe_queue_yumi_i & fe_queue_v_o & ~flush_i;

  assign exc_yumi_o   = w_enq & exc_v_i;
  assign fetch_yumi_o = w_enq & fetch_v_i & ~exc_v_i;

  // Message formation; exception wins, unused payload bits stay zero.
  always_comb begin
    w_msg = '0;
    if (exc_v_i) begin
      w_msg[fe_queue_width_lp-1] = e_fe_exception;
      w_msg[exc_w-1:0]           = {exc_vaddr_i, exc_code_i};
    end else begin
      w_msg[fe_queue_width_lp-1] = e_fe_fetch;
      w_msg[fetch_w-1:0]         = {fetch_pc_i, fetch_instr_i, fetch_br_metadata_i};
    end
  end

  // Pointer update; flush overrides any enqueue/dequeue in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + ptr_one;
      if (w_deq) r_rptr <= r_rptr + ptr_one;
    end
  end

  // Storage array write; contents are not reset, only the pointers are.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[idx_w-1:0]] <= w_msg;
  end

endmodule
